// File: rtl/text_term_if.sv
// Key handshake and text-buffer write port of the character-terminal write engine.
// slave = the write engine, master = the keyboard/buffer side that drives keys and observes writes.
interface text_term_if #(
  parameter int ADDR_W = 12
);
  logic              key_valid;
  logic [7:0]        key_ascii;
  logic              key_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [6:0]        cursor_col;
  logic [4:0]        cursor_row;
  logic              busy;

  modport master (
    output key_valid, key_ascii,
    input  key_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy
  );

  modport slave (
    input  key_valid, key_ascii,
    output key_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/text_term_writer.sv
// Character-terminal write engine: consumes ASCII keys, tracks the cursor and writes
// characters, blanks and row/screen clears into the COLS x ROWS text buffer, one write per cycle.
module text_term_writer #(
  parameter int COLS   = 70,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  text_term_if.slave  bus
);

  localparam logic [ADDR_W-1:0] CELLS_A  = ADDR_W'(COLS * ROWS);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);
  localparam logic [7:0]        BLANK    = 8'h20;

  typedef enum logic [1:0] {
    ST_CLR_ALL = 2'd0,
    ST_IDLE    = 2'd1,
    ST_CLR_ROW = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic [ADDR_W-1:0] clr_cnt_nxt_s;
  logic [6:0]        col_r;
  logic [6:0]        col_nxt_s;
  logic [4:0]        row_r;
  logic [4:0]        row_nxt_s;
  logic              wr_en_r;
  logic              wr_en_nxt_s;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [ADDR_W-1:0] wr_addr_nxt_s;
  logic [7:0]        wr_data_r;
  logic [7:0]        wr_data_nxt_s;
  logic              key_ready_r;
  logic              busy_r;

  logic              transfer_s;
  logic              is_print_s;
  logic              is_nl_s;
  logic              is_bs_s;
  logic              at_last_col_s;
  logic              at_last_row_s;
  logic              wrap_s;
  logic              clr_done_s;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    return (ADDR_W'(row) * COLS_A) + ADDR_W'(col);
  endfunction

  // Key classification, cursor boundaries and clear-sequence completion
  always_comb begin
    transfer_s    = bus.key_valid & key_ready_r;
    is_print_s    = (bus.key_ascii >= 8'h20) && (bus.key_ascii <= 8'h7E);
    is_nl_s       = (bus.key_ascii == 8'h0D) || (bus.key_ascii == 8'h0A);
    is_bs_s       = (bus.key_ascii == 8'h08);
    at_last_col_s = (col_r == LAST_COL);
    at_last_row_s = (row_r == LAST_ROW);
    wrap_s        = transfer_s && at_last_row_s && (is_nl_s || (is_print_s && at_last_col_s));
    clr_done_s    = 1'b0;
    case (state_r)
      ST_CLR_ALL: clr_done_s = (clr_cnt_r == CELLS_A);
      ST_CLR_ROW: clr_done_s = (clr_cnt_r == COLS_A);
      default:    clr_done_s = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_CLR_ALL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLR_ALL: begin
        if (clr_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLR_ALL;
        end
      end
      ST_IDLE: begin
        if (wrap_s) begin
          state_nxt_s = ST_CLR_ROW;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLR_ROW: begin
        if (clr_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLR_ROW;
        end
      end
      default: state_nxt_s = ST_CLR_ALL;
    endcase
  end

  // Output logic: next write strobe/address/data, cursor and clear counter
  always_comb begin
    wr_en_nxt_s   = 1'b0;
    wr_addr_nxt_s = wr_addr_r;
    wr_data_nxt_s = wr_data_r;
    col_nxt_s     = col_r;
    row_nxt_s     = row_r;
    clr_cnt_nxt_s = clr_cnt_r;
    case (state_r)
      ST_CLR_ALL: begin
        if (clr_done_s) begin
          clr_cnt_nxt_s = ZERO_A;
        end else begin
          wr_en_nxt_s   = 1'b1;
          wr_addr_nxt_s = clr_cnt_r;
          wr_data_nxt_s = BLANK;
          clr_cnt_nxt_s = clr_cnt_r + ONE_A;
        end
      end
      ST_CLR_ROW: begin
        if (clr_done_s) begin
          clr_cnt_nxt_s = ZERO_A;
        end else begin
          wr_en_nxt_s   = 1'b1;
          wr_addr_nxt_s = cell_addr(row_r, clr_cnt_r[6:0]);
          wr_data_nxt_s = BLANK;
          clr_cnt_nxt_s = clr_cnt_r + ONE_A;
        end
      end
      ST_IDLE: begin
        if (transfer_s && is_print_s) begin
          wr_en_nxt_s   = 1'b1;
          wr_addr_nxt_s = cell_addr(row_r, col_r);
          wr_data_nxt_s = bus.key_ascii;
          if (!at_last_col_s) begin
            col_nxt_s = col_r + 7'd1;
          end else if (at_last_row_s) begin
            // Screen wrap: the row clear starts on the next cycle from cell 0
            col_nxt_s     = 7'd0;
            row_nxt_s     = 5'd0;
            clr_cnt_nxt_s = ZERO_A;
          end else begin
            col_nxt_s = 7'd0;
            row_nxt_s = row_r + 5'd1;
          end
        end else if (transfer_s && is_nl_s) begin
          col_nxt_s = 7'd0;
          if (at_last_row_s) begin
            // Newline wrap issues the first row-0 blank now so the clear spans COLS cycles
            row_nxt_s     = 5'd0;
            wr_en_nxt_s   = 1'b1;
            wr_addr_nxt_s = cell_addr(5'd0, 7'd0);
            wr_data_nxt_s = BLANK;
            clr_cnt_nxt_s = ONE_A;
          end else begin
            row_nxt_s = row_r + 5'd1;
          end
        end else if (transfer_s && is_bs_s) begin
          if (col_r != 7'd0) begin
            col_nxt_s     = col_r - 7'd1;
            wr_en_nxt_s   = 1'b1;
            wr_addr_nxt_s = cell_addr(row_r, col_r - 7'd1);
            wr_data_nxt_s = BLANK;
          end else if (row_r != 5'd0) begin
            col_nxt_s     = LAST_COL;
            row_nxt_s     = row_r - 5'd1;
            wr_en_nxt_s   = 1'b1;
            wr_addr_nxt_s = cell_addr(row_r - 5'd1, LAST_COL);
            wr_data_nxt_s = BLANK;
          end else begin
            col_nxt_s = col_r;
          end
        end else begin
          col_nxt_s = col_r;
        end
      end
      default: begin
        wr_en_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered outputs, cursor and clear counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_r     <= 1'b0;
      wr_addr_r   <= ZERO_A;
      wr_data_r   <= BLANK;
      col_r       <= 7'd0;
      row_r       <= 5'd0;
      clr_cnt_r   <= ZERO_A;
      key_ready_r <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      wr_en_r     <= wr_en_nxt_s;
      wr_addr_r   <= wr_addr_nxt_s;
      wr_data_r   <= wr_data_nxt_s;
      col_r       <= col_nxt_s;
      row_r       <= row_nxt_s;
      clr_cnt_r   <= clr_cnt_nxt_s;
      key_ready_r <= (state_nxt_s == ST_IDLE);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.key_ready  = key_ready_r;
  assign bus.wr_en      = wr_en_r;
  assign bus.wr_addr    = wr_addr_r;
  assign bus.wr_data    = wr_data_r;
  assign bus.cursor_col = col_r;
  assign bus.cursor_row = row_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_text_term_writer.sv
// Scoreboard bench for text_term_writer: directed keys push expected buffer writes into a
// queue, and an independent monitor pops and compares every write the engine issues.
module tb_text_term_writer;
  localparam int ADDR_W = 12;
  localparam int COLS   = 70;
  localparam int ROWS   = 30;
  localparam int CELLS  = COLS * ROWS;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_w;

  text_term_if #(.ADDR_W(ADDR_W)) bus ();

  text_term_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %02h, expected no write (t=%0t)",
                 bus.wr_addr, bus.wr_data, $time);
      end else begin
        mon_w = exp_q.pop_front();
        check("write_addr", 32'(bus.wr_addr), 32'(mon_w[19:8]));
        check("write_data", 32'(bus.wr_data), 32'(mon_w[7:0]));
      end
    end
  end

  task automatic expect_write(input int addr, input logic [7:0] data);
    exp_q.push_back({12'(addr), data});
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wr_en"},     32'(bus.wr_en), 32'd0);
    check({tag, "_wr_addr"},   32'(bus.wr_addr), 32'd0);
    check({tag, "_wr_data"},   32'(bus.wr_data), 32'h20);
    check({tag, "_key_ready"}, 32'(bus.key_ready), 32'd0);
    check({tag, "_busy"},      32'(bus.busy), 32'd1);
    check({tag, "_col"},       32'(bus.cursor_col), 32'd0);
    check({tag, "_row"},       32'(bus.cursor_row), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge of the cycle after the transfer
  task automatic send_key(input logic [7:0] ch, input logic exp_wr, input int col, input int row);
    int waited = 0;
    bus.key_ascii = ch;
    bus.key_valid = 1'b1;
    while (bus.key_ready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (bus.key_ready !== 1'b1) begin
      check($sformatf("key_ready_timeout_%02h", ch), 32'(bus.key_ready), 32'd1);
      bus.key_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    @(negedge clk);
    check($sformatf("wr_en_after_%02h", ch), 32'(bus.wr_en), 32'(exp_wr));
    check($sformatf("col_after_%02h", ch), 32'(bus.cursor_col), 32'(col));
    check($sformatf("row_after_%02h", ch), 32'(bus.cursor_row), 32'(row));
  endtask

  task automatic key_write(input logic [7:0] ch, input int addr, input logic [7:0] data,
                           input int col, input int row);
    expect_write(addr, data);
    send_key(ch, 1'b1, col, row);
  endtask

  // Releases reset and checks one complete screen clear
  task automatic run_clear_all(input string tag);
    int hi = 0;
    for (int i = 0; i < CELLS; i++) expect_write(i, 8'h20);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_pre_wr_en"}, 32'(bus.wr_en), 32'd0);
    check({tag, "_pre_busy"}, 32'(bus.busy), 32'd1);
    for (int i = 0; i < CELLS; i++) begin
      @(negedge clk);
      if (bus.wr_en === 1'b1) hi++;
    end
    check({tag, "_write_cycles"}, 32'(hi), 32'(CELLS));
    @(negedge clk);
    check({tag, "_post_wr_en"}, 32'(bus.wr_en), 32'd0);
    check({tag, "_post_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_post_key_ready"}, 32'(bus.key_ready), 32'd1);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // From column 0 or later on row 0, newlines down to row ROWS-1 (no writes)
  task automatic newlines_to_bottom();
    for (int k = 1; k < ROWS; k++) begin
      send_key((k % 2 == 1) ? 8'h0A : 8'h0D, 1'b0, 0, k);
    end
  endtask

  initial begin
    logic [7:0] c;
    int hold_bad;
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_ascii = 8'h00;

    // Reset values and full screen clear
    repeat (3) @(negedge clk);
    check_reset("reset");
    run_clear_all("clr_all");

    // 'A','B' at the home position
    key_write(8'h41, 0, 8'h41, 1, 0);
    key_write(8'h42, 1, 8'h42, 2, 0);

    // Backspace back to home, blanking both cells
    key_write(8'h08, 1, 8'h20, 1, 0);
    key_write(8'h08, 0, 8'h20, 0, 0);

    // 71 printable characters: the 71st lands at addr 70, cursor (1,1)
    for (int i = 0; i < 71; i++) begin
      c = 8'h41 + 8'(i % 26);
      key_write(c, i, c, (i + 1) % COLS, (i + 1) / COLS);
    end

    // Backspace across the row boundary, then down to home and beyond
    key_write(8'h08, 70, 8'h20, 0, 1);
    key_write(8'h08, 69, 8'h20, 69, 0);
    for (int k = 68; k >= 0; k--) key_write(8'h08, k, 8'h20, k, 0);
    send_key(8'h08, 1'b0, 0, 0);
    send_key(8'h07, 1'b0, 0, 0);
    send_key(8'h7F, 1'b0, 0, 0);
    send_key(8'h1B, 1'b0, 0, 0);

    // Newline wrap from the bottom row: row-0 clear while a held key waits
    key_write(8'h78, 0, 8'h78, 1, 0);
    newlines_to_bottom();
    for (int i = 0; i < COLS; i++) expect_write(i, 8'h20);
    send_key(8'h0D, 1'b1, 0, 0);
    bus.key_ascii = 8'h5A;
    bus.key_valid = 1'b1;
    hold_bad = 0;
    if (bus.busy !== 1'b1 || bus.key_ready !== 1'b0) hold_bad++;
    for (int i = 1; i < COLS; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.key_ready !== 1'b0 || bus.wr_en !== 1'b1) hold_bad++;
    end
    check("row_clear_hold_cycles", 32'(hold_bad), 32'd0);
    @(negedge clk);
    check("row_clear_done_busy", 32'(bus.busy), 32'd0);
    check("row_clear_done_key_ready", 32'(bus.key_ready), 32'd1);
    check("row_clear_done_wr_en", 32'(bus.wr_en), 32'd0);
    key_write(8'h5A, 0, 8'h5A, 1, 0);

    // Printable wrap on the last cell: char at 2099, then row-0 clear
    newlines_to_bottom();
    for (int j = 0; j < COLS - 1; j++) begin
      key_write(8'h61, (ROWS - 1) * COLS + j, 8'h61, j + 1, ROWS - 1);
    end
    expect_write(CELLS - 1, 8'h7A);
    for (int i = 0; i < COLS; i++) expect_write(i, 8'h20);
    send_key(8'h7A, 1'b1, 0, 0);
    check("last_cell_busy", 32'(bus.busy), 32'd1);
    repeat (COLS) @(negedge clk);
    @(negedge clk);
    check("last_cell_done_busy", 32'(bus.busy), 32'd0);
    check("last_cell_done_key_ready", 32'(bus.key_ready), 32'd1);
    check("last_cell_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a row clear, then a full restart
    newlines_to_bottom();
    for (int i = 0; i <= 30; i++) expect_write(i, 8'h20);
    send_key(8'h0D, 1'b1, 0, 0);
    repeat (30) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset("mid_reset");
    check("mid_reset_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check_reset("mid_reset_hold");
    run_clear_all("restart");
    key_write(8'h51, 0, 8'h51, 1, 0);

    @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
